rgb_pwm_sequencer: RTL and testbench

//  Parametrised N-channel PWM LED controller; successor to the fixed 3-bit colour stepper.

---
 rtl/rgb_pwm_sequencer_pkg.sv | 19 +
 rtl/rgb_pwm_sequencer_if.sv | 27 ++
 rtl/rgb_pwm_sequencer_channel.sv | 37 +++
 rtl/rgb_pwm_sequencer.sv | 126 ++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared constants for the RGB PWM sequencer: mode codes, breathe FSM states
// and a width helper that never returns zero.
package rgb_pwm_pkg;

  localparam logic [1:0] MODE_STATIC  = 2'd0;
  localparam logic [1:0] MODE_STEP    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } br_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_if.sv
// Control/status bundle between a host and the PWM sequencer.
interface rgb_pwm_sequencer_if
  import rgb_pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
);
  localparam int SEL_W = clog2_min1(CHANNELS);

  logic [1:0]          mode;
  logic                duty_wr;
  logic [SEL_W-1:0]    duty_sel;
  logic [PWM_BITS-1:0] duty_data;
  logic [CHANNELS-1:0] pwm_out;
  logic [CHANNELS-1:0] colour_idx;
  logic                frame_tick;

  modport master (
    output mode, duty_wr, duty_sel, duty_data,
    input  pwm_out, colour_idx, frame_tick
  );

  modport slave (
    input  mode, duty_wr, duty_sel, duty_data,
    output pwm_out, colour_idx, frame_tick
  );
endinterface

// File: rtl/rgb_pwm_sequencer_channel.sv
// One PWM output: duty register, boundary-latched shadow and registered compare.
// o_duty forwards a same-cycle write so the shadow can capture it at a boundary.
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr,
  input  logic [PWM_BITS-1:0] i_data,
  input  logic [PWM_BITS-1:0] i_duty_eff,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_boundary,
  input  logic                i_force_off,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_pwm
);
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_shadow;
  logic                r_pwm;

  assign o_duty = i_wr ? i_data : r_duty;
  assign o_pwm  = r_pwm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty   <= '0;
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr)
        r_duty <= i_data;
      if (i_boundary)
        r_shadow <= i_duty_eff;
      r_pwm <= !i_force_off && (i_pwm_cnt < r_shadow);
    end
  end
endmodule

// File: rtl/rgb_pwm_sequencer.sv
// N-channel PWM LED sequencer: shared timebase, colour stepper and breathe
// envelope feeding one pwm_channel per output.
module rgb_pwm_sequencer
  import rgb_pwm_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 16,
  parameter int STEP_FRAMES = 244
) (
  input  logic               clk,
  input  logic               rst,
  rgb_pwm_sequencer_if.slave bus
);
  localparam int SEL_W   = clog2_min1(CHANNELS);
  localparam int PRE_W   = clog2_min1(PRESCALE);
  localparam int FRAME_W = clog2_min1(STEP_FRAMES);
  localparam logic [PWM_BITS-1:0] LVL_PRE_TOP = ~PWM_BITS'(1);

  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [CHANNELS-1:0] r_colour;
  logic [1:0]          r_mode_act;
  logic                r_frame_tick;
  br_state_t           r_br_state;
  br_state_t           w_br_next;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_level_next;
  logic [CHANNELS-1:0] w_colour_next;
  logic [CHANNELS-1:0] w_pwm;
  logic                w_tick;
  logic                w_boundary;
  logic                w_step_evt;
  logic                w_force_off;

  assign w_tick        = (r_pre_cnt == PRE_W'(PRESCALE - 1));
  assign w_boundary    = w_tick && (&r_pwm_cnt);
  assign w_step_evt    = w_boundary && (r_frame_cnt == FRAME_W'(STEP_FRAMES - 1));
  assign w_colour_next = w_step_evt ? r_colour + 1'b1 : r_colour;
  // OFF acts immediately on entry but is only released at a boundary.
  assign w_force_off   = (bus.mode == MODE_OFF) || (r_mode_act == MODE_OFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt    <= '0;
      r_pwm_cnt    <= '0;
      r_frame_cnt  <= '0;
      r_colour     <= '0;
      r_mode_act   <= MODE_STATIC;
      r_frame_tick <= 1'b0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick)
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_boundary) begin
        r_frame_cnt <= w_step_evt ? '0 : r_frame_cnt + 1'b1;
        r_mode_act  <= bus.mode;
      end
      r_colour     <= w_colour_next;
      r_frame_tick <= w_boundary;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_state <= BR_UP;
      r_level    <= '0;
    end else begin
      r_br_state <= w_br_next;
      r_level    <= w_level_next;
    end
  end

  // Turn in the same step that reaches the end value, so 0 and max occur once.
  always_comb begin
    w_br_next = r_br_state;
    if (w_step_evt) begin
      case (r_br_state)
        BR_UP:   if (r_level == LVL_PRE_TOP)  w_br_next = BR_DOWN;
        BR_DOWN: if (r_level == PWM_BITS'(1)) w_br_next = BR_UP;
      endcase
    end
  end

  always_comb begin
    w_level_next = r_level;
    if (w_step_evt)
      w_level_next = (r_br_state == BR_UP) ? r_level + 1'b1 : r_level - 1'b1;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [PWM_BITS-1:0]   w_duty;
    logic [PWM_BITS-1:0]   w_eff;
    logic [2*PWM_BITS-1:0] w_prod;

    // Shadow sees the mode, colour and level that take effect this boundary.
    assign w_prod = {{PWM_BITS{1'b0}}, w_duty} * {{PWM_BITS{1'b0}}, w_level_next};

    always_comb begin
      w_eff = w_duty;
      case (bus.mode)
        MODE_STEP:    w_eff = w_colour_next[gi] ? w_duty : '0;
        MODE_BREATHE: w_eff = w_prod[2*PWM_BITS-1:PWM_BITS];
        default:      w_eff = w_duty;
      endcase
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_wr        (bus.duty_wr && (bus.duty_sel == SEL_W'(gi))),
      .i_data      (bus.duty_data),
      .i_duty_eff  (w_eff),
      .i_pwm_cnt   (r_pwm_cnt),
      .i_boundary  (w_boundary),
      .i_force_off (w_force_off),
      .o_duty      (w_duty),
      .o_pwm       (w_pwm[gi])
    );
  end

  assign bus.pwm_out    = w_pwm;
  assign bus.colour_idx = r_colour;
  assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Scoreboard bench for rgb_pwm_sequencer: an expected high-time per channel is
// queued at every period start and compared when the period closes.
module tb_rgb_pwm_sequencer;
  import rgb_pwm_pkg::*;

  localparam int CH   = 3;
  localparam int PB   = 4;
  localparam int PS   = 2;
  localparam int SF   = 2;
  localparam int PER  = PS * (1 << PB);
  localparam int LMAX = (1 << PB) - 1;

  typedef struct packed {
    logic              skip;
    logic [CH-1:0]     colour;
    logic [CH-1:0][5:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_pwm_sequencer_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus ();

  rgb_pwm_sequencer #(
    .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS), .STEP_FRAMES(SF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference timebase: clocks since reset release.
  int unsigned cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  exp_t       sb[$];
  int         m_duty[CH];
  logic [1:0] m_mode;
  logic [1:0] m_mode_act;
  int         acc[CH];
  bit         saw_ft;
  int         n_checks;
  int         n_fail;

  function automatic int level_of(input int s);
    int r;
    r = s % (2 * LMAX);
    return (r <= LMAX) ? r : 2 * LMAX - r;
  endfunction

  function automatic int eff_of(input int ch, input int b);
    int steps;
    int colour;
    steps  = b / SF;
    colour = steps % (1 << CH);
    case (m_mode)
      MODE_STATIC:  return m_duty[ch];
      MODE_STEP:    return ((colour >> ch) & 1) != 0 ? m_duty[ch] : 0;
      MODE_BREATHE: return (m_duty[ch] * level_of(steps)) >> PB;
      default:      return 0;
    endcase
  endfunction

  task automatic step_cycle();
    bit   ft_exp;
    int   b;
    exp_t e;
    @(negedge clk);
    ft_exp = (cyc != 0) && (cyc % PER == 0);
    n_checks++;
    if (bus.frame_tick !== ft_exp) begin
      n_fail++;
      $display("FAIL frame_tick cyc=%0d got=%b want=%b", cyc, bus.frame_tick, ft_exp);
    end
    if (m_mode == MODE_OFF || m_mode_act == MODE_OFF) begin
      n_checks++;
      if (bus.pwm_out !== '0) begin
        n_fail++;
        $display("FAIL force_off cyc=%0d pwm_out got=%b want=000", cyc, bus.pwm_out);
      end
    end
    for (int i = 0; i < CH; i++) acc[i] += int'(bus.pwm_out[i]);
    saw_ft = ft_exp;
    if (ft_exp) begin
      b = int'(cyc) / PER;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.skip) begin
          for (int i = 0; i < CH; i++) begin
            n_checks++;
            if (acc[i] !== int'(e.cnt[i])) begin
              n_fail++;
              $display("FAIL high_time period=%0d ch=%0d got=%0d want=%0d", b - 1, i, acc[i], e.cnt[i]);
            end
          end
        end
        $display("period %0d mode=%0d colour=%0d high=%0d/%0d/%0d", b - 1, m_mode_act, e.colour, acc[0], acc[1], acc[2]);
      end
      m_mode_act = m_mode;
      e.skip     = 1'b0;
      e.colour   = CH'((b / SF) % (1 << CH));
      for (int i = 0; i < CH; i++)
        e.cnt[i] = 6'((m_mode_act == MODE_OFF) ? 0 : PS * eff_of(i, b));
      n_checks++;
      if (bus.colour_idx !== e.colour) begin
        n_fail++;
        $display("FAIL colour_idx period=%0d got=%0d want=%0d", b, bus.colour_idx, e.colour);
      end
      sb.push_back(e);
      for (int i = 0; i < CH; i++) acc[i] = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic wait_ft();
    bit got;
    got = 1'b0;
    for (int i = 0; i < PER + 8; i++) begin
      step_cycle();
      if (saw_ft) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL wait_ft timeout got=none want=frame_tick");
    end
  endtask

  task automatic to_phase(input int p);
    for (int i = 0; i < PER + 8; i++) begin
      if (int'(cyc % PER) == p) break;
      step_cycle();
    end
  endtask

  task automatic write_duty(input int ch, input int val);
    bus.duty_wr   = 1'b1;
    bus.duty_sel  = ch[1:0];
    bus.duty_data = val[PB-1:0];
    if (ch < CH) m_duty[ch] = val;
    $display("write ch=%0d data=%0d cyc=%0d", ch, val, cyc);
    step_cycle();
    bus.duty_wr = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.mode = m;
    if (m == MODE_OFF && m_mode != MODE_OFF && sb.size() > 0)
      sb[sb.size() - 1].skip = 1'b1;
    m_mode = m;
    $display("mode=%0d cyc=%0d", m, cyc);
  endtask

  task automatic model_reset();
    sb.delete();
    m_mode_act = MODE_STATIC;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0;
      acc[i]    = 0;
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.pwm_out !== '0 || bus.colour_idx !== '0 || bus.frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%b/%b want=000/000/0", bus.pwm_out, bus.colour_idx, bus.frame_tick);
    end
    rst = 1'b0;
    for (int i = 0; i < CH; i++) write_duty(i, LMAX);
    run_cycles(5 * PER);
    wait_ft();
    run_cycles(3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (bus.pwm_out !== '0 || bus.colour_idx !== '0 || bus.frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got=%b/%b/%b want=000/000/0", bus.pwm_out, bus.colour_idx, bus.frame_tick);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 1; i <= PER + 8; i++) begin
        step_cycle();
        if (saw_ft) begin
          n = i;
          break;
        end
      end
      n_checks++;
      if (n !== PER) begin
        n_fail++;
        $display("FAIL ft_spacing k=%0d got=%0d want=%0d", k, n, PER);
      end
    end
  endtask

  task automatic test_static();
    set_mode(MODE_STATIC);
    write_duty(0, 4);
    write_duty(1, 0);
    write_duty(2, LMAX);
    wait_ft();
    wait_ft();
    step_cycle();
    n_checks++;
    if (bus.pwm_out !== 3'b101) begin
      n_fail++;
      $display("FAIL static_first got=%b want=101", bus.pwm_out);
    end
    run_cycles(3 * PER);
  endtask

  task automatic test_duty_update();
    wait_ft();
    to_phase(10);
    write_duty(0, 8);
    wait_ft();
    to_phase(PER - 1);
    write_duty(0, 2);
    n_checks++;
    if (!saw_ft) begin
      n_fail++;
      $display("FAIL boundary_write_align got=no_ft want=ft");
    end
    run_cycles(2 * PER + 4);
  endtask

  task automatic test_step();
    for (int i = 0; i < CH; i++) write_duty(i, LMAX);
    set_mode(MODE_STEP);
    run_cycles(18 * PER);
  endtask

  task automatic test_breathe();
    write_duty(0, LMAX);
    write_duty(1, 8);
    write_duty(2, 0);
    set_mode(MODE_BREATHE);
    run_cycles(64 * PER);
  endtask

  task automatic test_off();
    set_mode(MODE_STATIC);
    write_duty(0, LMAX);
    write_duty(1, 6);
    write_duty(2, 0);
    run_cycles(2 * PER);
    wait_ft();
    run_cycles(5);
    n_checks++;
    if (bus.pwm_out !== 3'b011) begin
      n_fail++;
      $display("FAIL pre_off got=%b want=011", bus.pwm_out);
    end
    set_mode(MODE_OFF);
    step_cycle();
    n_checks++;
    if (bus.pwm_out !== 3'b000) begin
      n_fail++;
      $display("FAIL off_next_clk got=%b want=000", bus.pwm_out);
    end
    write_duty(3, 7);
    run_cycles(2 * PER);
    wait_ft();
    run_cycles(10);
    set_mode(MODE_STATIC);
    wait_ft();
    step_cycle();
    n_checks++;
    if (bus.pwm_out !== 3'b011) begin
      n_fail++;
      $display("FAIL resume got=%b want=011", bus.pwm_out);
    end
    run_cycles(2 * PER + 4);
  endtask

  initial begin
    bus.mode      = MODE_STATIC;
    bus.duty_wr   = 1'b0;
    bus.duty_sel  = '0;
    bus.duty_data = '0;
    m_mode        = MODE_STATIC;
    n_checks      = 0;
    n_fail        = 0;
    saw_ft        = 1'b0;
    model_reset();
    rst = 1'b1;
    test_reset();
    test_static();
    test_duty_update();
    test_step();
    test_breathe();
    test_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
